// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and hazard scoreboard for the 8 x 16-bit register file.
// Shares the single register-file write port between the ALU and load
// write-back sources with round-robin on ties, registers one write per cycle,
// and keeps a saturating pending-write count per register so issue logic can
// detect read-after-write hazards and select the forwarding path.
module regfile_wb_sched #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    // ALU write-back request
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    // Load write-back request
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    // Issue of an instruction writing issue_rd
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_stall,
    // Source operands of the instruction being decoded
    input  logic [AW-1:0] rd_a,
    input  logic [AW-1:0] rd_b,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic          byp_a,
    output logic          byp_b,
    // Register file write port
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          err
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t     lastGrant;
    logic [1:0] cnt     [NREG];
    logic [1:0] cntNext [NREG];
    logic       effIssue;
    logic       commitZero;
    logic [1:0] cntIssue;
    logic [1:0] cntA;
    logic [1:0] cntB;

    // Arbitration: a lone requester always wins; on a tie the source that
    // did not win last time goes first. Ready never looks at wr_en.
    assign alu_ready = alu_valid & (~mem_valid | (lastGrant == GRANT_MEM));
    assign mem_ready = mem_valid & (~alu_valid | (lastGrant == GRANT_ALU));

    // Issue is refused only when the counter is full and no commit to the
    // same register frees a slot in this very cycle.
    assign cntIssue    = cnt[issue_rd];
    assign issue_stall = issue_valid & (cntIssue == 2'd3)
                       & ~(wr_en & (wr_addr == issue_rd));
    assign effIssue    = issue_valid & ~issue_stall;

    // The write leaving the port this cycle is the forwarding source; a
    // single outstanding write that is committing now is no longer a hazard.
    assign cntA     = cnt[rd_a];
    assign cntB     = cnt[rd_b];
    assign byp_a    = wr_en & (wr_addr == rd_a);
    assign byp_b    = wr_en & (wr_addr == rd_b);
    assign hazard_a = (cntA > 2'd1) | ((cntA == 2'd1) & ~byp_a);
    assign hazard_b = (cntB > 2'd1) | ((cntB == 2'd1) & ~byp_b);

    // Round-robin pointer, moved only by an accepted request.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= GRANT_ALU;
        end else if (mem_ready) begin
            lastGrant <= GRANT_MEM;
        end else if (alu_ready) begin
            lastGrant <= GRANT_ALU;
        end
    end

    // Registered write port: an accept becomes a commit on the next cycle;
    // address and data hold when idle so the port does not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= alu_ready | mem_ready;
            if (mem_ready) begin
                wr_addr <= mem_rd;
                wr_data <= mem_data;
            end else if (alu_ready) begin
                wr_addr <= alu_rd;
                wr_data <= alu_data;
            end
        end
    end

    // Next pending counts: +1 on an effective issue, -1 on a commit, net zero
    // when both hit the same register; a commit never takes a count below 0.
    // NOTE: every combinational output gets its default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        commitZero = wr_en & (cnt[wr_addr] == 2'd0);
        for (int r = 0; r < NREG; r++) begin
            cntNext[r] = cnt[r];
            if (effIssue && (issue_rd == AW'(r)) && !(wr_en && (wr_addr == AW'(r)))) begin
                cntNext[r] = cnt[r] + 2'd1;
            end else if (wr_en && (wr_addr == AW'(r)) && !(effIssue && (issue_rd == AW'(r)))) begin
                if (cnt[r] != 2'd0) begin
                    cntNext[r] = cnt[r] - 2'd1;
                end
            end
        end
    end

    // Pending-write counters.
    // NOTE: this small array is real control state, so it is reset like any
    // flop; only pure data storage would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cntNext[r];
            end
        end
    end

    // Sticky error: a commit arrived for a register with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (commitZero) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched. Expected writes are pushed into a
// scoreboard queue when a request is modelled as accepted and popped when the
// write port commits; hazard, bypass, stall and error flags are checked
// against values worked out per scenario.
module tb_regfile_wb_sched;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_stall;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] rd_b;
    logic          hazard_a;
    logic          hazard_b;
    logic          byp_a;
    logic          byp_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          err;

    wr_t  expQ[$];
    logic mLastMem;
    int   nChecks = 0;
    int   nPass   = 0;

    regfile_wb_sched #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .byp_a       (byp_a),
        .byp_b       (byp_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat,
                         input logic iv, input logic [AW-1:0] ird);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adat;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = mdat;
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    endtask

    // One clock: check readies against the arbitration model, push the
    // expected write, then after the edge pop and compare the write port.
    task automatic tick(input string tag);
        logic expAlu;
        logic expMem;
        wr_t  w;
        expAlu = alu_valid & (~mem_valid | mLastMem);
        expMem = mem_valid & (~alu_valid | ~mLastMem);
        #1;
        check({tag, "/alu_ready"}, alu_ready, expAlu);
        check({tag, "/mem_ready"}, mem_ready, expMem);
        if (expMem) begin
            expQ.push_back(wr_t'{addr: mem_rd, data: mem_data});
            mLastMem = 1'b1;
        end else if (expAlu) begin
            expQ.push_back(wr_t'{addr: alu_rd, data: alu_data});
            mLastMem = 1'b0;
        end
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            w = expQ.pop_front();
            check({tag, "/wr_en"}, wr_en, 1'b1);
            check({tag, "/wr_addr"}, wr_addr, w.addr);
            check({tag, "/wr_data"}, wr_data, w.data);
        end else begin
            check({tag, "/wr_en_idle"}, wr_en, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic resetPulse();
        idle();
        rst_n = 1'b0;
        expQ.delete();
        mLastMem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        mLastMem = 1'b0;
        rd_a     = '0;
        rd_b     = '0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst/wr_en", wr_en, 1'b0);
        check("rst/wr_addr", wr_addr, 3'd0);
        check("rst/wr_data", wr_data, 16'h0);
        check("rst/err", err, 1'b0);
        check("rst/issue_stall", issue_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie arbitration: MEM wins first, then alternation; r6 issued once.
        rd_a = 3'd6;
        drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b1, 3'd6);
        #1;
        check("tie/issue_stall", issue_stall, 1'b0);
        tick("tie0");
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b0, 3'd0);
            tick($sformatf("tie%0d", i));
        end
        // Commit of r2 still in flight; err set by commits to empty counters.
        idle();
        #1;
        check("tie/err", err, 1'b1);
        check("tie/hazard_r6", hazard_a, 1'b1);
        check("tie/wr_en_inflight", wr_en, 1'b1);

        // Asynchronous reset in the middle of the cycle.
        #1;
        rst_n = 1'b0;
        expQ.delete();
        mLastMem = 1'b0;
        #1;
        check("arst/wr_en", wr_en, 1'b0);
        check("arst/err", err, 1'b0);
        check("arst/hazard_a", hazard_a, 1'b0);
        check("arst/wr_addr", wr_addr, 3'd0);
        check("arst/wr_data", wr_data, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            rd_a = AW'(r);
            #0.5;
            check($sformatf("arst/hazard_a_r%0d", r), hazard_a, 1'b0);
        end
        @(negedge clk);

        // Hazard lifecycle on r5, watched from both source ports.
        rd_a = 3'd5;
        rd_b = 3'd5;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
        #1;
        check("haz/pre_issue", hazard_a, 1'b0);
        tick("haz_issue");
        drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        #1;
        check("haz/pending_a", hazard_a, 1'b1);
        check("haz/pending_b", hazard_b, 1'b1);
        check("haz/pending_byp", byp_a, 1'b0);
        tick("haz_req");
        idle();
        #1;
        check("haz/commit_hazard_a", hazard_a, 1'b0);
        check("haz/commit_byp_a", byp_a, 1'b1);
        check("haz/commit_hazard_b", hazard_b, 1'b0);
        check("haz/commit_byp_b", byp_b, 1'b1);
        tick("haz_commit");
        check("haz/after_hazard", hazard_a, 1'b0);
        check("haz/after_byp", byp_a, 1'b0);
        check("haz/after_err", err, 1'b0);

        // Saturation of r4.
        rd_a = 3'd4;
        rd_b = 3'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
            #1;
            check($sformatf("sat/issue%0d_stall", i), issue_stall, 1'b0);
            tick($sformatf("sat_issue%0d", i));
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        #1;
        check("sat/full_stall", issue_stall, 1'b1);
        check("sat/full_hazard", hazard_a, 1'b1);
        tick("sat_full");
        drive(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        #1;
        check("sat/req_stall", issue_stall, 1'b1);
        tick("sat_req");
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        #1;
        check("sat/commit_stall", issue_stall, 1'b0);
        check("sat/commit_byp", byp_a, 1'b1);
        check("sat/commit_hazard", hazard_a, 1'b1);
        tick("sat_commit");
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        #1;
        check("sat/still_full", issue_stall, 1'b1);
        tick("sat_still");
        // Drain exactly three writes: the counter must end at zero.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd4, 16'h4440 | 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
            tick($sformatf("sat_drain%0d", i));
        end
        idle();
        tick("sat_drain_last");
        check("sat/drained_hazard", hazard_a, 1'b0);
        check("sat/drained_err", err, 1'b0);

        // Spurious commit to r1.
        resetPulse();
        rd_a = 3'd1;
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h1234, 1'b0, 3'd0);
        tick("sp_req");
        idle();
        #1;
        check("sp/err_commit_cycle", err, 1'b0);
        tick("sp_commit");
        check("sp/err_set", err, 1'b1);
        check("sp/hazard", hazard_a, 1'b0);
        tick("sp_idle0");
        tick("sp_idle1");
        check("sp/err_sticky", err, 1'b1);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
        #1;
        check("sp/issue_stall", issue_stall, 1'b0);
        tick("sp_issue");
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h5678, 1'b0, 3'd0);
        #1;
        check("sp/one_pending", hazard_a, 1'b1);
        tick("sp_req2");
        idle();
        tick("sp_commit2");
        check("sp/cleared_hazard", hazard_a, 1'b0);
        check("sp/cleared_byp", byp_a, 1'b0);
        check("sp/err_still", err, 1'b1);

        // Back-to-back ALU writes r0..r7 with mem idle.
        resetPulse();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(i), 16'hA000 | 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
            tick($sformatf("b2b%0d", i));
        end
        idle();
        tick("b2b_end");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and hazard scoreboard for the 8 x 16-bit register file. The register file has one write port; this block shares it between the ALU and load/store write-back sources. Each request is presented as a valid/ready handshake, and the block registers one write per cycle onto the write port. It also tracks outstanding writes per register so issue logic can detect read-after-write hazards and pick up the forwarding path.

## Interface
Parameters:
- DW, 16, data width
- AW, 3, register address width (NREG = 2**AW = 8)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU write-back request
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  load write-back request
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load request accepted this cycle (combinational)
- issue_valid  in  1  an instruction with destination issue_rd is issued
- issue_rd  in  AW  destination of issued instruction
- issue_stall  out  1  issue_rd pending counter saturated; the issue is refused (combinational)
- rd_a, rd_b  in  AW  source registers of the instruction being decoded
- hazard_a, hazard_b  out  1  source has an outstanding write that is not being committed this cycle
- byp_a, byp_b  out  1  source matches the write committing this cycle; use wr_data
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  AW  register file write address (registered)
- wr_data  out  DW  register file write data (registered)
- err  out  1  sticky: a commit occurred to a register with pending count 0

## Operation
- **Arbitration:**
  - alu_ready = alu_valid & (~mem_valid | last_grant==MEM).
  - mem_ready = mem_valid & (~alu_valid | last_grant==ALU).
  - When both sources are valid, round-robin applies. last_grant updates only on an accepted request. Its reset value is ALU, so MEM wins the first tie.
- **Write port:**
  - On an accept, the next edge loads wr_en=1 and wr_addr/wr_data from the granted source.
  - With no accept, wr_en loads 0, and wr_addr/wr_data hold their values.
- **Scoreboard:**
  - cnt[r] is a 2-bit pending-write counter per register.
  - An effective issue (issue_valid & ~issue_stall) increments cnt[issue_rd].
  - A commit (wr_en=1) decrements cnt[wr_addr].
  - If both hit the same register in one cycle, cnt is unchanged.
  - issue_stall = issue_valid & cnt[issue_rd]==3 & ~(wr_en & wr_addr==issue_rd).
- **Commit to a zero count:** cnt stays 0 and err sets. err clears only on reset.
- **Hazard and bypass, for each source x in {a, b}:**
  - byp_x = wr_en & wr_addr==rd_x.
  - hazard_x = cnt[rd_x]>1, or (cnt[rd_x]==1 & ~byp_x).
- **Register 7 (PC):** no special casing; it is scheduled like the other registers.

## Timing
- **Reset values:** wr_en=0, wr_addr=0, wr_data=0, all cnt=0, last_grant=ALU, err=0. Every combinational output follows from this state.
- **Reset mid-operation:** clears all state immediately, including an in-flight wr_en. Accepted requests that have not yet committed are lost, and the requester must reissue them.
- **Latency:**
  - An accept at edge T drives wr_en high during cycle T+1.
  - cnt decrements at edge T+1, so the change is visible from T+2.
- **Throughput:** one commit per cycle, with back-to-back accepts allowed.
- **Handshake:** a requester holds valid and its payload stable until ready. Ready never depends on wr_en.
- **Commit and issue to the same register in one cycle:** the net cnt change is 0; byp_x reflects the committing value.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle. Required: wr_en, err and hazards drop to 0 asynchronously; after release, hazard_a=0 for all rd_a.
- **Tie arbitration:** hold alu_valid and mem_valid with rd 2 and 3, data 0x1111 and 0x2222, for 4 cycles. Required: grants go MEM, ALU, MEM, ALU; the wr_addr sequence is 3, 2, 3, 2.
- **Hazard lifecycle:** issue rd=5, then ALU writes r5=0xBEEF.
  - With rd_a=5: hazard_a=1 until the commit cycle.
  - In the commit cycle: hazard_a=0, byp_a=1, wr_data=0xBEEF.
  - Afterwards: cnt[5]=0.
- **Saturation:** issue rd=4 three times, then issue again. Required: issue_stall=1 with cnt unchanged. Then commit r4 while issue_rd=4. Required: issue_stall=0, the issue is accepted, and cnt[4] stays 3.
- **Spurious commit:** a mem write to r1 with cnt[1]=0. Required: err=1 and sticky, cnt[1]=0.
- **Back-to-back ALU writes:** ALU writes r0..r7 on consecutive cycles with mem idle. Required: wr_en stays high for 8 consecutive cycles, and wr_addr increments from 0 to 7.
